// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                operation encodings, FSM state encodings and width defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_unit_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 5;

    typedef logic [1:0] op_t;

    // Bit 1 selects divide, bit 0 selects unsigned.
    localparam op_t OP_MULT  = 2'b00;
    localparam op_t OP_MULTU = 2'b01;
    localparam op_t OP_DIV   = 2'b10;
    localparam op_t OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic opIsDiv(input op_t o);
        return o[1];
    endfunction

    function automatic logic opIsSigned(input op_t o);
        return ~o[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO
//                registers. One bit per cycle (shift-add multiply, restoring
//                divide), followed by a sign fix-up / write-back cycle.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk    in   1      rising-edge clock
//    rst    in   1      synchronous active-low reset
//    start  in   1      launch op with a, b (accepted only when idle)
//    op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//    a      in   WIDTH  rs operand
//    b      in   WIDTH  rt operand
//    mthi   in   1      write a into HI (idle only)
//    mtlo   in   1      write a into LO (idle only)
//    cancel in   1      abort running op (only with MULDIV_CANCEL_EN)
//    hi     out  WIDTH  HI register
//    lo     out  WIDTH  LO register
//    busy   out  1      operation in progress
//    done   out  1      one-cycle pulse, HI/LO hold a fresh result
//
//  Build option: define MULDIV_CANCEL_EN to add the cancel input.
// ============================================================================
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_isDiv;
    logic             r_divZero;
    logic             r_signQ;
    logic             r_signR;
    // Multiplicand, divisor, or raw dividend when dividing by zero.
    logic [WIDTH-1:0] r_opnd;
    // Multiply: upper product half. Divide: partial remainder.
    logic [WIDTH-1:0] r_accHi;
    // Multiply: multiplier shifting out / product low half shifting in.
    // Divide: dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] r_accLo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_cancel;
    logic             w_signed;
    logic             w_divOp;
    logic             w_divZero;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic             w_divGe;
    logic [WIDTH-1:0] w_divDiff;
    logic [WIDTH-1:0] w_fixHi;
    logic [WIDTH-1:0] w_fixLo;
    logic [2*WIDTH-1:0] w_prodFix;

`ifdef MULDIV_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] negIf(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negIfWide(input logic neg, input logic [2*WIDTH-1:0] v);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Operand conditioning at the accept edge.
    assign w_signed  = opIsSigned(op);
    assign w_divOp   = opIsDiv(op);
    assign w_divZero = w_divOp && (b == '0);
    assign w_absA    = (w_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_absB    = (w_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set, then shift the whole {accHi, accLo} pair right by one.
    assign w_mulSum = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opnd} : '0);

    // Restoring step: the remainder stays below the divisor, so the shifted
    // value needs one extra bit but the difference always fits in WIDTH.
    assign w_divShift = {r_accHi, r_accLo[WIDTH-1]};
    assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opnd;

    assign w_prodFix = negIfWide(r_signQ, {r_accHi, r_accLo});

    always_comb begin
        w_fixHi = '0;
        w_fixLo = '0;
        if (r_divZero) begin
            w_fixHi = r_opnd;
            w_fixLo = '1;
        end else if (r_isDiv) begin
            w_fixHi = negIf(r_signR, r_accHi);
            w_fixLo = negIf(r_signQ, r_accLo);
        end else begin
            w_fixHi = w_prodFix[2*WIDTH-1:WIDTH];
            w_fixLo = w_prodFix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            r_signQ   <= 1'b0;
            r_signR   <= 1'b0;
            r_opnd    <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cancel && (r_state != ST_IDLE)) begin
                // Flush: drop the partial result, HI/LO untouched.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_isDiv   <= w_divOp;
                            r_divZero <= w_divZero;
                            r_signQ   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_signR   <= w_signed & a[WIDTH-1];
                            r_cnt     <= '0;
                            r_accHi   <= '0;
                            if (w_divZero) begin
                                // HI receives the untouched dividend.
                                r_opnd  <= a;
                                r_accLo <= '0;
                                r_state <= ST_FIX;
                            end else begin
                                r_opnd  <= w_divOp ? w_absB : w_absA;
                                r_accLo <= w_divOp ? w_absA : w_absB;
                                r_state <= ST_CALC;
                            end
                        end else begin
                            if (mthi) begin
                                r_hi <= a;
                            end
                            if (mtlo) begin
                                r_lo <= a;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_isDiv) begin
                            r_accHi <= w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
                            r_accLo <= {r_accLo[WIDTH-2:0], w_divGe};
                        end else begin
                            r_accHi <= w_mulSum[WIDTH:1];
                            r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
                        end
                        if (r_cnt == c_LAST_ITER) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        r_hi    <= w_fixHi;
                        r_lo    <= w_fixLo;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed vector table,
//                randomized operations against an arithmetic reference model,
//                and hand-written sequences for the multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
`ifdef MULDIV_CANCEL_EN
    logic        cancel = 1'b0;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int nChecks = 0;
    int nFail   = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
`ifdef MULDIV_CANCEL_EN
        .cancel(cancel),
`endif
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eHi, output logic [31:0] eLo);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        eHi = '0;
        eLo = '0;
        case (o)
            OP_MULT: begin
                p = 64'(sx * sy);
                eHi = p[63:32];
                eLo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                eHi = p[63:32];
                eLo = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    eHi = x;
                    eLo = 32'hFFFF_FFFF;
                end else begin
                    if (o == OP_DIV) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = longint'({32'd0, x}) / longint'({32'd0, y});
                        r = longint'({32'd0, x}) % longint'({32'd0, y});
                    end
                    p = 64'(q);
                    eLo = p[31:0];
                    p = 64'(r);
                    eHi = p[31:0];
                end
            end
        endcase
    endfunction

    // Called at posedge+1. Launches one op and waits (bounded) for done.
    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rHi, output logic [31:0] rLo,
                         output int lat, output int busyCnt, output logic busyAtDone,
                         output logic timedOut);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busyCnt = 0; timedOut = 1'b1;
        rHi = '0; rLo = '0; busyAtDone = 1'b1;
        if (busy) busyCnt++;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                timedOut = 1'b0;
                rHi = hi;
                rLo = lo;
                busyAtDone = busy;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic resetDut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    logic [31:0] rHi, rLo, eHi, eLo;
    int          lat, busyCnt, doneCnt;
    logic        busyAtDone, timedOut;

    initial begin
        vecs[0] = '{"mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33};
        vecs[1] = '{"multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{"divu_7_0",      OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1};
        vecs[4] = '{"div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[5] = '{"div_m7_0",      OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
        vecs[6] = '{"divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};

        resetDut();
        @(posedge clk); #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, rHi, rLo, lat, busyCnt, busyAtDone, timedOut);
            check({vecs[i].name, "_timeout"}, {31'd0, timedOut}, 32'd0);
            check({vecs[i].name, "_hi"}, rHi, vecs[i].expHi);
            check({vecs[i].name, "_lo"}, rLo, vecs[i].expLo);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].expLat));
            check({vecs[i].name, "_busy_until_done"}, 32'(busyCnt), 32'(vecs[i].expLat));
            check({vecs[i].name, "_busy_at_done"}, {31'd0, busyAtDone}, 32'd0);
            @(posedge clk); #1;
            check({vecs[i].name, "_done_single"}, {31'd0, done}, 32'd0);
        end

        // Randomized against the model
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 4)  rb = 32'($urandom_range(1, 40)) ^ ((sel == 3) ? 32'hFFFF_FFFF : 32'd0);
            else               rb = $urandom;
            if (sel == 9) ra = 32'h8000_0000;
            model(ro, ra, rb, eHi, eLo);
            runOp(ro, ra, rb, rHi, rLo, lat, busyCnt, busyAtDone, timedOut);
            check("rand_timeout", {31'd0, timedOut}, 32'd0);
            check("rand_hi", rHi, eHi);
            check("rand_lo", rLo, eLo);
            check("rand_latency", 32'(lat), (ro[1] && rb == 32'd0) ? 32'd1 : 32'd33);
        end

        // mthi / mtlo in IDLE
        a = 32'h1234; mthi = 1'b1;
        @(posedge clk); #1;
        a = 32'h5678; mthi = 1'b0; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mthi_idle", hi, 32'h1234);
        check("mtlo_idle", lo, 32'h5678);
        a = 32'hCAFE_0001; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_both_hi", hi, 32'hCAFE_0001);
        check("mthilo_both_lo", lo, 32'hCAFE_0001);

        // start together with moves: the move is dropped
        op = OP_MULTU; a = 32'd5; b = 32'd6; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_prio_hi", hi, 32'hCAFE_0001);
        check("start_prio_lo", lo, 32'hCAFE_0001);
        // moves and a second start while busy are ignored; HI/LO hold
        a = 32'hDEAD_BEEF; b = 32'd3; op = OP_DIVU; mthi = 1'b1; mtlo = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
        check("busy_move_hi", hi, 32'hCAFE_0001);
        check("busy_move_lo", lo, 32'hCAFE_0001);
        doneCnt = 0;
        rHi = '0; rLo = '0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) begin
                doneCnt++;
                rHi = hi;
                rLo = lo;
            end
        end
        check("one_done_pulse", 32'(doneCnt), 32'd1);
        check("busy_ignored_hi", rHi, 32'd0);
        check("busy_ignored_lo", rLo, 32'd30);

        // Back-to-back: start accepted in the done cycle
        runOp(OP_MULT, 32'd7, 32'hFFFF_FFFF, rHi, rLo, lat, busyCnt, busyAtDone, timedOut);
        check("b2b_first_lo", rLo, 32'hFFFF_FFF9);
        op = OP_MULTU; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        timedOut = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        check("b2b_timeout", {31'd0, timedOut}, 32'd0);
        check("b2b_second_lo", lo, 32'd81);

        // Reset in the middle of a DIVU
        a = 32'h1111_2222; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
        end
        check("midrst_no_done", 32'(doneCnt), 32'd0);

`ifdef MULDIV_CANCEL_EN
        a = 32'h0BAD_F00D; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        op = OP_MULT; a = 32'd12; b = 32'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, 32'h0BAD_F00D);
        check("cancel_lo", lo, 32'h0BAD_F00D);
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) doneCnt++;
        end
        check("cancel_no_done", 32'(doneCnt), 32'd0);
        // cancel in IDLE does not block a start
        op = OP_MULTU; a = 32'd4; b = 32'd5; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_idle_accept", {31'd0, busy}, 32'd1);
        timedOut = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
        end
        check("cancel_idle_timeout", {31'd0, timedOut}, 32'd0);
        check("cancel_idle_lo", lo, 32'd20);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
